// File: rtl/rpn_stack_ram.sv
// rpn_stack_ram - operand stack for the RPN datapath.
//
// The top two entries (top, next) are held in registers so the ALU always
// sees both operands. Entries below them spill into a synchronous-read RAM
// (one write port, one registered read port). Entry k (k >= 2, counting
// from the top) lives at mem[count-1-k], so the RAM fills from address 0
// upward, like an ordinary stack.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   push            push din (strobe)
//   pop             discard top (strobe)
//   reduce          replace top and next with din (strobe)
//   clear           empty the stack and clear the error flags
//   din             value for push/reduce
//   top, next       entries 0 and 1 (registered; 0 when the slot is unused)
//   count           entries held, 0..DEPTH
//   empty, full     count==0, count==DEPTH
//   ready           1 = push/pop/reduce accepted this cycle
//   overflow_err    sticky, set by push while full
//   underflow_err   sticky, set by pop on empty or reduce with < 2 entries
//
// FSM states:
//   state  | meaning
//   IDLE   | ready; ops accepted
//   REFILL | one cycle; next is reloaded from the RAM read data
module rpn_stack_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          reduce,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         top,
  output logic [DATA_WIDTH-1:0]         next,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty,
  output logic                          full,
  output logic                          ready,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CW         = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);
  localparam logic [CW-1:0] THREE   = CW'(3);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   top_d, next_d;
  logic [CW-1:0]           count_d;
  logic                    ovf_d, unf_d;

  logic                    wr_en, rd_en;
  logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Spill RAM. Not reset. A write and a read never target the same address
  // in one cycle: writes happen only on push, reads only on pop/reduce.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= next;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      top           <= '0;
      next          <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      top           <= top_d;
      next          <= next_d;
      count         <= count_d;
      overflow_err  <= ovf_d;
      underflow_err <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    top_d   = top;
    next_d  = next;
    count_d = count;
    ovf_d   = overflow_err;
    unf_d   = underflow_err;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    ready   = (state_q == IDLE);

    if (clear) begin
      // Clear wins over everything, including an in-flight refill.
      state_d = IDLE;
      top_d   = '0;
      next_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (state_q == REFILL) begin
      // Read data was captured on the op edge; push/pop/reduce are ignored.
      next_d  = rd_data;
      state_d = IDLE;
    end else if (push) begin
      if (count == DEPTH_C) begin
        ovf_d = 1'b1;
      end else begin
        if (count >= TWO) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_WIDTH'(count - TWO);
        end
        next_d  = top;
        top_d   = din;
        count_d = count + ONE;
      end
    end else if (pop) begin
      if (count == '0) begin
        unf_d = 1'b1;
      end else begin
        // With a single entry next is already 0, so top falls to 0.
        top_d   = next;
        count_d = count - ONE;
        if (count >= THREE) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_WIDTH'(count - THREE);
          state_d = REFILL;
        end else begin
          next_d = '0;
        end
      end
    end else if (reduce) begin
      if (count < TWO) begin
        unf_d = 1'b1;
      end else begin
        top_d   = din;
        count_d = count - ONE;
        if (count >= THREE) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_WIDTH'(count - THREE);
          state_d = REFILL;
        end else begin
          next_d = '0;
        end
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

endmodule

// File: tb/tb_rpn_stack_ram.sv
module tb_rpn_stack_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0, pop = 1'b0, reduce = 1'b0, clear = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] top, nxt;
  logic [4:0] count;
  logic       empty, full, ready, overflow_err, underflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpn_stack_ram #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .reduce(reduce),
    .clear(clear), .din(din), .top(top), .next(nxt), .count(count),
    .empty(empty), .full(full), .ready(ready),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  // kind: 0 idle, 1 push, 2 pop, 3 reduce, 4 clear, 5 push+pop, 6 clear+push
  typedef struct {
    int         kind;
    logic [7:0] din;
    logic [7:0] top;
    logic [7:0] nxt;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  typedef struct {
    logic [7:0] top;
    logic [7:0] nxt;
    int         cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int kind, input logic [7:0] d);
    @(negedge clk);
    din    = d;
    push   = (kind == 1 || kind == 5 || kind == 6);
    pop    = (kind == 2 || kind == 5);
    reduce = (kind == 3);
    clear  = (kind == 4 || kind == 6);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; reduce = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    if (!ready) begin
      errors++;
      $display("FAIL ready_timeout: ready stuck at 0, expected 1 within 8 cycles");
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    chk({tag, ".top"}, 32'(top), 32'(e.top));
    chk({tag, ".next"}, 32'(nxt), 32'(e.nxt));
    chk({tag, ".count"}, 32'(count), 32'(e.cnt));
    chk({tag, ".empty"}, 32'(empty), 32'(e.cnt == 0));
    chk({tag, ".full"}, 32'(full), 32'(e.cnt == 16));
    chk({tag, ".ovf"}, 32'(overflow_err), 32'(e.ovf));
    chk({tag, ".unf"}, 32'(underflow_err), 32'(e.unf));
  endtask

  task automatic apply_op(input string tag, input int kind, input logic [7:0] d, input exp_t e);
    drive(kind, d);
    sb.push_back(e);
    wait_ready();
    if (sb.size() != 0) check_state(tag, sb.pop_front());
  endtask

  function automatic exp_t mk(input logic [7:0] t, input logic [7:0] n, input int c,
                              input logic o, input logic u);
    exp_t e;
    e.top = t; e.nxt = n; e.cnt = c; e.ovf = o; e.unf = u;
    return e;
  endfunction

  initial begin
    vecs.push_back('{4, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h11, 8'h11, 8'h00, 1, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h22, 8'h22, 8'h11, 2, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h33, 8'h33, 8'h22, 3, 1'b0, 1'b0});
    vecs.push_back('{2, 8'h00, 8'h22, 8'h11, 2, 1'b0, 1'b0});
    vecs.push_back('{2, 8'h00, 8'h11, 8'h00, 1, 1'b0, 1'b0});
    vecs.push_back('{2, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0});
    vecs.push_back('{2, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1});
    vecs.push_back('{4, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h05, 8'h05, 8'h00, 1, 1'b0, 1'b0});
    vecs.push_back('{3, 8'h07, 8'h05, 8'h00, 1, 1'b0, 1'b1});
    vecs.push_back('{4, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h02, 8'h02, 8'h00, 1, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h03, 8'h03, 8'h02, 2, 1'b0, 1'b0});
    vecs.push_back('{1, 8'h04, 8'h04, 8'h03, 3, 1'b0, 1'b0});
    vecs.push_back('{3, 8'h07, 8'h07, 8'h02, 2, 1'b0, 1'b0});
    vecs.push_back('{3, 8'h09, 8'h09, 8'h00, 1, 1'b0, 1'b0});
    vecs.push_back('{1, 8'hAA, 8'hAA, 8'h09, 2, 1'b0, 1'b0});
    vecs.push_back('{1, 8'hBB, 8'hBB, 8'hAA, 3, 1'b0, 1'b0});
    vecs.push_back('{1, 8'hCC, 8'hCC, 8'hBB, 4, 1'b0, 1'b0});
    vecs.push_back('{1, 8'hDD, 8'hDD, 8'hCC, 5, 1'b0, 1'b0});
    vecs.push_back('{5, 8'hEE, 8'hEE, 8'hDD, 6, 1'b0, 1'b0});
    vecs.push_back('{2, 8'h00, 8'hDD, 8'hCC, 5, 1'b0, 1'b0});
    vecs.push_back('{3, 8'h42, 8'h42, 8'hBB, 4, 1'b0, 1'b0});
    vecs.push_back('{6, 8'h77, 8'h00, 8'h00, 0, 1'b0, 1'b0});

    // Reset values
    #12;
    chk("rst.top", 32'(top), 32'h0);
    chk("rst.next", 32'(nxt), 32'h0);
    chk("rst.count", 32'(count), 32'h0);
    chk("rst.ready", 32'(ready), 32'h1);
    chk("rst.empty", 32'(empty), 32'h1);
    chk("rst.errs", 32'({overflow_err, underflow_err}), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_op($sformatf("vec%0d", i), vecs[i].kind, vecs[i].din,
               mk(vecs[i].top, vecs[i].nxt, vecs[i].cnt, vecs[i].ovf, vecs[i].unf));
    end

    // Refill timing: ready drops for exactly one cycle after a deep pop.
    drive(4, 8'h00);
    drive(1, 8'h11); drive(1, 8'h22); drive(1, 8'h33);
    chk("p1.ready", 32'(ready), 32'h1);
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    chk("p2.top", 32'(top), 32'h22);
    chk("p2.ready_low", 32'(ready), 32'h0);
    chk("p2.count", 32'(count), 32'h2);
    @(negedge clk);
    chk("p2.next", 32'(nxt), 32'h11);
    chk("p2.ready_high", 32'(ready), 32'h1);

    // Fill to DEPTH, overflow, then drain.
    drive(4, 8'h00);
    for (int i = 1; i <= 16; i++)
      apply_op($sformatf("fill%0d", i), 1, 8'(i),
               mk(8'(i), (i > 1) ? 8'(i - 1) : 8'h00, i, 1'b0, 1'b0));
    apply_op("ovf", 1, 8'hAA, mk(8'h10, 8'h0F, 16, 1'b1, 1'b0));
    for (int k = 1; k <= 16; k++)
      apply_op($sformatf("drain%0d", k), 2, 8'h00,
               mk(8'(16 - k), (k < 15) ? 8'(15 - k) : 8'h00, 16 - k, 1'b1, 1'b0));

    // Push strobe during REFILL is ignored.
    drive(4, 8'h00);
    drive(1, 8'h02); drive(1, 8'h03); drive(1, 8'h04);
    @(negedge clk); din = 8'h07; reduce = 1'b1;
    @(negedge clk); reduce = 1'b0;
    chk("r5.ready_low", 32'(ready), 32'h0);
    din = 8'h99; push = 1'b1;
    @(negedge clk); push = 1'b0;
    wait_ready();
    check_state("r5", mk(8'h07, 8'h02, 2, 1'b0, 1'b0));

    // Clear during REFILL aborts it and clears errors.
    drive(4, 8'h00);
    drive(2, 8'h00);
    drive(1, 8'h11); drive(1, 8'h22); drive(1, 8'h33);
    chk("c6.unf_set", 32'(underflow_err), 32'h1);
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    chk("c6.ready_low", 32'(ready), 32'h0);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("c6.ready", 32'(ready), 32'h1);
    check_state("c6", mk(8'h00, 8'h00, 0, 1'b0, 1'b0));

    // Asynchronous reset during REFILL.
    drive(2, 8'h00);
    drive(1, 8'h11); drive(1, 8'h22); drive(1, 8'h33);
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    chk("a6.ready_low", 32'(ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("a6.ready", 32'(ready), 32'h1);
    check_state("a6", mk(8'h00, 8'h00, 0, 1'b0, 1'b0));
    @(negedge clk); rst_n = 1'b1;
    apply_op("a6.post", 1, 8'h5A, mk(8'h5A, 8'h00, 1, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
